dma_burst_scheduler: RTL and testbench
======================================

Name: dma_burst_scheduler

Overview:
- Sequences the shared AHB transfer engine between NUM_CHAN DMA channels.
- Holds per-channel transfer state (source, destination, remaining words) and splits each transfer into bursts of at most BURST_MAX words.
- Picks a channel round-robin at burst granularity and issues one burst command per grant over a valid/ready handshake.
- Tracks burst completion and errors from the engine; raises per-channel done/error status to the register/interrupt block.

Parameters:
- NUM_CHAN, 4, number of channels (power of 2).
- ADDR_W, 32, address width; byte addresses, word-aligned.
- LEN_W, 16, transfer length width, in 32-bit words.
- BURST_MAX, 16, maximum beats per burst (power of 2, ≤256).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ch_start  in  NUM_CHAN  per-channel start pulse; loads that channel's config.
- ch_src  in  NUM_CHAN*ADDR_W  source addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_dst  in  NUM_CHAN*ADDR_W  destination addresses, same packing as ch_src.
- ch_len  in  NUM_CHAN*LEN_W  lengths in words.
- ch_busy  out  NUM_CHAN  channel has words outstanding.
- ch_done  out  NUM_CHAN  one-cycle pulse when a channel completes.
- ch_err  out  NUM_CHAN  sticky error flag; cleared by that channel's ch_start.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  engine accepts the command.
- cmd_chan  out  $clog2(NUM_CHAN)  channel owning the command.
- cmd_src  out  ADDR_W  burst source address.
- cmd_dst  out  ADDR_W  burst destination address.
- cmd_beats  out  $clog2(BURST_MAX)+1  beat count, 1..BURST_MAX.
- xfer_done  in  1  one-cycle pulse: accepted burst completed.
- xfer_err  in  1  one-cycle pulse: accepted burst failed (replaces xfer_done).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - ch_busy, ch_done, ch_err, cmd_valid = 0; cmd_* fields = 0.
  - State = IDLE; rr_ptr = 0; all per-channel registers = 0.
  - Reset mid-burst abandons the burst; the engine is reset by the same rst_n.
- Channel load: ch_start[i] while !ch_busy[i]:
  - Registers src/dst/len for channel i and clears ch_err[i].
  - If len≠0, ch_busy[i]=1 the next cycle.
  - If len=0, ch_done[i] pulses the next cycle and busy stays 0.
  - ch_start[i] while ch_busy[i] is ignored and does not clear ch_err[i].
  - Loads are accepted in any state, including for channels other than the in-flight one.
- FSM states: IDLE, ARB, ISSUE, WAIT.
  - IDLE: go to ARB when any ch_busy bit is 1.
  - ARB (1 cycle):
    - Winner = first busy channel scanning from rr_ptr upward with wrap.
    - rr_ptr ← (winner+1) mod NUM_CHAN.
    - Latch cmd_chan, cmd_src, cmd_dst and cmd_beats, then go to ISSUE.
    - If no channel is busy, return to IDLE.
  - ISSUE:
    - cmd_valid=1; all cmd_* fields stay stable until cmd_valid && cmd_ready.
    - On handshake: cmd_valid=0 the next cycle; go to WAIT.
  - WAIT:
    - Ignore xfer_done/xfer_err in every state other than WAIT.
    - On xfer_done: remaining -= beats; src += 4*beats; dst += 4*beats (mod 2^ADDR_W).
      - If remaining becomes 0: ch_done pulses and ch_busy clears in the same cycle.
      - Then go to ARB if any channel is busy (including new loads), else IDLE.
    - On xfer_err: ch_err[chan]=1 and ch_busy[chan]=0; no ch_done pulse; go to ARB or IDLE as above.
- Beat count: beats = min(remaining, BURST_MAX, words to the next 1 KB boundary of src, words to the next 1 KB boundary of dst).
  - Words to boundary = (1024 - addr[9:0]) >> 2.
  - No burst crosses a 1 KB boundary on either side.
- Latency:
  - ch_start at edge T → ch_busy at T+1 → ARB at T+1 → cmd_valid at T+2 (scheduler idle).
  - Back-to-back: xfer_done at edge T → cmd_valid for the next burst at T+2.
- Fairness: arbitration is per burst, so long transfers interleave with other busy channels.
- Engine contract: at most one burst is outstanding at any time.

Test Plan:
- ch0 src=0x1000 dst=0x2000 len=40 → three bursts (0x1000/0x2000/16), (0x1040/0x2040/16), (0x1080/0x2080/8); ch_done[0] pulses once after the third xfer_done.
- ch0..ch3 started in the same cycle, len=16 each, cmd_ready=1 → cmd_chan order 0,1,2,3, each burst 16 beats; four ch_done pulses in that order.
- ch0 and ch2 started in the same cycle, len=32 each → cmd_chan order 0,2,0,2; ch1 started mid-way is inserted at its round-robin turn.
- ch1 src=0x3F0 dst=0x0 len=16 → bursts of 4 beats (0x3F0) then 12 beats (0x400/0x10).
- ch3 len=0 → ch_done[3] pulses at T+1 with no command. ch2 burst answered with xfer_err → ch_err[2]=1, ch_busy[2]=0, no done pulse; a later ch_start[2] clears ch_err[2].
- cmd_ready held low 5 cycles → cmd_valid and all cmd_* fields stable for the whole wait. rst_n=0 during WAIT → all outputs 0 the next cycle; a restart of ch0 runs from fresh config.

Source files
------------

// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler: shares one AHB transfer engine between NUM_CHAN DMA
// channels. Each channel's transfer is split into bursts of at most BURST_MAX
// words that never cross a 1 KB boundary on either the source or the
// destination side. Channels are granted round-robin, one burst per grant.
//
// Command handshake: cmd_valid rises with all cmd_* fields already valid and
// holds them stable until the cycle in which cmd_valid && cmd_ready are both
// high at a clk edge; cmd_valid drops the following cycle. After that, exactly
// one xfer_done or xfer_err pulse closes the burst; these pulses are ignored
// unless a burst is outstanding.
module dma_burst_scheduler #(
  parameter int NUM_CHAN  = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BURST_MAX = 16,
  localparam int CW = $clog2(NUM_CHAN),
  localparam int BW = $clog2(BURST_MAX) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CHAN-1:0]        ch_start,
  input  logic [NUM_CHAN*ADDR_W-1:0] ch_src,
  input  logic [NUM_CHAN*ADDR_W-1:0] ch_dst,
  input  logic [NUM_CHAN*LEN_W-1:0]  ch_len,
  output logic [NUM_CHAN-1:0]        ch_busy,
  output logic [NUM_CHAN-1:0]        ch_done,
  output logic [NUM_CHAN-1:0]        ch_err,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [CW-1:0]              cmd_chan,
  output logic [ADDR_W-1:0]          cmd_src,
  output logic [ADDR_W-1:0]          cmd_dst,
  output logic [BW-1:0]              cmd_beats,
  input  logic                       xfer_done,
  input  logic                       xfer_err,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  localparam logic [BW-1:0]    BM_BW  = BW'(BURST_MAX);
  localparam logic [8:0]       BM_9   = 9'(BURST_MAX);
  localparam logic [LEN_W-1:0] BM_LEN = LEN_W'(BURST_MAX);

  state_e                state_q, state_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [ADDR_W-1:0]     src_q [NUM_CHAN];
  logic [ADDR_W-1:0]     src_d [NUM_CHAN];
  logic [ADDR_W-1:0]     dst_q [NUM_CHAN];
  logic [ADDR_W-1:0]     dst_d [NUM_CHAN];
  logic [LEN_W-1:0]      rem_q [NUM_CHAN];
  logic [LEN_W-1:0]      rem_d [NUM_CHAN];
  logic [NUM_CHAN-1:0]   busy_q, busy_d;
  logic [NUM_CHAN-1:0]   done_q, done_d;
  logic [NUM_CHAN-1:0]   err_q, err_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [CW-1:0]         cmd_chan_q, cmd_chan_d;
  logic [ADDR_W-1:0]     cmd_src_q, cmd_src_d;
  logic [ADDR_W-1:0]     cmd_dst_q, cmd_dst_d;
  logic [BW-1:0]         cmd_beats_q, cmd_beats_d;

  logic                  win_found;
  logic [CW-1:0]         win_idx;
  logic [CW-1:0]         scan_idx;
  logic [8:0]            src_room, dst_room;
  logic [BW-1:0]         win_beats;
  logic [LEN_W-1:0]      rem_after;

  // Clamp a word count to BURST_MAX, returned at beat-count width.
  function automatic logic [BW-1:0] clamp_room(input logic [8:0] r);
    return (r >= BM_9) ? BM_BW : r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] min_beats(input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Round-robin pick: first busy channel at or after rr_q, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      scan_idx = rr_q + CW'(i);
      if (!win_found && busy_q[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Burst size for the winner: min of remaining, BURST_MAX and the words left
  // before the next 1 KB boundary of src and of dst.
  always_comb begin
    src_room  = 9'd256 - {1'b0, src_q[win_idx][9:2]};
    dst_room  = 9'd256 - {1'b0, dst_q[win_idx][9:2]};
    win_beats = (rem_q[win_idx] >= BM_LEN) ? BM_BW : rem_q[win_idx][BW-1:0];
    win_beats = min_beats(win_beats, clamp_room(src_room));
    win_beats = min_beats(win_beats, clamp_room(dst_room));
  end

  assign rem_after = rem_q[cmd_chan_q] - {{(LEN_W-BW){1'b0}}, cmd_beats_q};

  // Channel loads, FSM next state and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = '0;
    err_d       = err_q;
    cmd_valid_d = cmd_valid_q;
    cmd_chan_d  = cmd_chan_q;
    cmd_src_d   = cmd_src_q;
    cmd_dst_d   = cmd_dst_q;
    cmd_beats_d = cmd_beats_q;

    // A start on an idle channel loads it; starts on busy channels are dropped.
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (ch_start[i] && !busy_q[i]) begin
        src_d[i] = ch_src[i*ADDR_W +: ADDR_W];
        dst_d[i] = ch_dst[i*ADDR_W +: ADDR_W];
        rem_d[i] = ch_len[i*LEN_W +: LEN_W];
        err_d[i] = 1'b0;
        if (ch_len[i*LEN_W +: LEN_W] != '0) busy_d[i] = 1'b1;
        else                                done_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|busy_d) state_d = S_ARB;
      end
      S_ARB: begin
        if (win_found) begin
          cmd_chan_d  = win_idx;
          cmd_src_d   = src_q[win_idx];
          cmd_dst_d   = dst_q[win_idx];
          cmd_beats_d = win_beats;
          cmd_valid_d = 1'b1;
          rr_d        = win_idx + CW'(1);
          state_d     = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (xfer_err) begin
          err_d[cmd_chan_q]  = 1'b1;
          busy_d[cmd_chan_q] = 1'b0;
          state_d = (|busy_d) ? S_ARB : S_IDLE;
        end else if (xfer_done) begin
          rem_d[cmd_chan_q] = rem_after;
          src_d[cmd_chan_q] = src_q[cmd_chan_q] + {{(ADDR_W-BW-2){1'b0}}, cmd_beats_q, 2'b00};
          dst_d[cmd_chan_q] = dst_q[cmd_chan_q] + {{(ADDR_W-BW-2){1'b0}}, cmd_beats_q, 2'b00};
          if (rem_after == '0) begin
            done_d[cmd_chan_q] = 1'b1;
            busy_d[cmd_chan_q] = 1'b0;
          end
          state_d = (|busy_d) ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and channel registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_chan_q  <= '0;
      cmd_src_q   <= '0;
      cmd_dst_q   <= '0;
      cmd_beats_q <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_chan_q  <= cmd_chan_d;
      cmd_src_q   <= cmd_src_d;
      cmd_dst_q   <= cmd_dst_d;
      cmd_beats_q <= cmd_beats_d;
      for (int i = 0; i < NUM_CHAN; i++) begin
        src_q[i] <= src_d[i];
        dst_q[i] <= dst_d[i];
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign ch_busy   = busy_q;
  assign ch_done   = done_q;
  assign ch_err    = err_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_chan  = cmd_chan_q;
  assign cmd_src   = cmd_src_q;
  assign cmd_dst   = cmd_dst_q;
  assign cmd_beats = cmd_beats_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler: small engine responder driven from
// tasks, hand-computed burst expectations, one checking task.
module tb_dma_burst_scheduler;
  localparam int NUM_CHAN  = 4;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 16;
  localparam int BURST_MAX = 16;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_CHAN-1:0]        ch_start;
  logic [NUM_CHAN*ADDR_W-1:0] ch_src;
  logic [NUM_CHAN*ADDR_W-1:0] ch_dst;
  logic [NUM_CHAN*LEN_W-1:0]  ch_len;
  logic [NUM_CHAN-1:0]        ch_busy, ch_done, ch_err;
  logic                       cmd_valid, cmd_ready;
  logic [1:0]                 cmd_chan;
  logic [ADDR_W-1:0]          cmd_src, cmd_dst;
  logic [4:0]                 cmd_beats;
  logic                       xfer_done, xfer_err;
  logic [1:0]                 dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  dma_burst_scheduler #(
    .NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_beats(cmd_beats),
    .xfer_done(xfer_done), .xfer_err(xfer_err), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len);
    ch_src[ch*ADDR_W +: ADDR_W] = src;
    ch_dst[ch*ADDR_W +: ADDR_W] = dst;
    ch_len[ch*LEN_W +: LEN_W]   = len;
  endtask

  task automatic start(input logic [3:0] mask);
    ch_start = mask;
    tick();
    ch_start = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  ch_busy,   4'h0);
    chk({tag, "_done"},  ch_done,   4'h0);
    chk({tag, "_err"},   ch_err,    4'h0);
    chk({tag, "_valid"}, cmd_valid, 1'b0);
    chk({tag, "_chan"},  cmd_chan,  2'd0);
    chk({tag, "_src"},   cmd_src,   32'h0);
    chk({tag, "_dst"},   cmd_dst,   32'h0);
    chk({tag, "_beats"}, cmd_beats, 5'd0);
    chk({tag, "_state"}, dbg_state, 2'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    tick();
    check_idle_outputs(tag);
    rst_n = 1'b1;
  endtask

  // driver: wait for a command, check it, accept it, then close it with
  // xfer_done or xfer_err and check done/busy right after.
  task automatic do_burst(input string tag, input logic [1:0] ech, input logic [31:0] esrc,
                          input logic [31:0] edst, input logic [4:0] ebeats, input bit err,
                          input logic [3:0] mid_start, input logic [3:0] edone,
                          input logic [3:0] ebusy);
    int n;
    n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_valid) begin
      chk({tag, "_cmd_timeout"}, 1'b0, 1'b1);
    end else begin
      chk({tag, "_chan"},  cmd_chan,  ech);
      chk({tag, "_src"},   cmd_src,   esrc);
      chk({tag, "_dst"},   cmd_dst,   edst);
      chk({tag, "_beats"}, cmd_beats, ebeats);
      tick();
      chk({tag, "_valid_drop"}, cmd_valid, 1'b0);
      tick();
      xfer_done = !err;
      xfer_err  = err;
      ch_start  = mid_start;
      tick();
      xfer_done = 1'b0;
      xfer_err  = 1'b0;
      ch_start  = '0;
      chk({tag, "_done"}, ch_done, edone);
      chk({tag, "_busy"}, ch_busy, ebusy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_start  = '0;
    ch_src    = '0;
    ch_dst    = '0;
    ch_len    = '0;
    cmd_ready = 1'b1;
    xfer_done = 1'b0;
    xfer_err  = 1'b0;

    // Reset state
    do_reset("reset");

    // T1: ch0 len 40 split 16/16/8, start and back-to-back latency
    set_cfg(0, 32'h1000, 32'h2000, 16'd40);
    start(4'b0001);
    chk("t1_busy_after_start", ch_busy, 4'b0001);
    chk("t1_no_valid_yet", cmd_valid, 1'b0);
    tick();
    chk("t1_start_latency", cmd_valid, 1'b1);
    do_burst("t1_b0", 2'd0, 32'h1000, 32'h2000, 5'd16, 0, 4'h0, 4'h0, 4'b0001);
    tick();
    chk("t1_b2b_latency", cmd_valid, 1'b1);
    do_burst("t1_b1", 2'd0, 32'h1040, 32'h2040, 5'd16, 0, 4'h0, 4'h0, 4'b0001);
    do_burst("t1_b2", 2'd0, 32'h1080, 32'h2080, 5'd8,  0, 4'h0, 4'b0001, 4'h0);
    tick();
    chk("t1_done_one_pulse", ch_done, 4'h0);
    chk("t1_idle_state", dbg_state, 2'd0);

    // T2: all four channels together, round-robin from 0
    do_reset("reset2");
    for (int i = 0; i < 4; i++) set_cfg(i, 32'(i) * 32'h1000, 32'h8000 + 32'(i) * 32'h1000, 16'd16);
    start(4'b1111);
    do_burst("t2_c0", 2'd0, 32'h0000, 32'h8000, 5'd16, 0, 4'h0, 4'b0001, 4'b1110);
    do_burst("t2_c1", 2'd1, 32'h1000, 32'h9000, 5'd16, 0, 4'h0, 4'b0010, 4'b1100);
    do_burst("t2_c2", 2'd2, 32'h2000, 32'hA000, 5'd16, 0, 4'h0, 4'b0100, 4'b1000);
    do_burst("t2_c3", 2'd3, 32'h3000, 32'hB000, 5'd16, 0, 4'h0, 4'b1000, 4'b0000);

    // T3: ch0/ch2 interleave, ch1 joins mid-way at its turn
    do_reset("reset3");
    set_cfg(0, 32'h0000, 32'h4000, 16'd32);
    set_cfg(2, 32'h0800, 32'h6000, 16'd32);
    set_cfg(1, 32'h0C00, 32'h7000, 16'd16);
    start(4'b0101);
    do_burst("t3_a", 2'd0, 32'h0000, 32'h4000, 5'd16, 0, 4'h0, 4'h0, 4'b0101);
    do_burst("t3_b", 2'd2, 32'h0800, 32'h6000, 5'd16, 0, 4'h0, 4'h0, 4'b0101);
    do_burst("t3_c", 2'd0, 32'h0040, 32'h4040, 5'd16, 0, 4'b0010, 4'b0001, 4'b0110);
    do_burst("t3_d", 2'd1, 32'h0C00, 32'h7000, 5'd16, 0, 4'h0, 4'b0010, 4'b0100);
    do_burst("t3_e", 2'd2, 32'h0840, 32'h6040, 5'd16, 0, 4'h0, 4'b0100, 4'b0000);

    // T4: 1 KB boundary split on the source side
    do_reset("reset4");
    set_cfg(1, 32'h03F0, 32'h0000, 16'd16);
    start(4'b0010);
    do_burst("t4_a", 2'd1, 32'h03F0, 32'h0000, 5'd4,  0, 4'h0, 4'h0, 4'b0010);
    do_burst("t4_b", 2'd1, 32'h0400, 32'h0010, 5'd12, 0, 4'h0, 4'b0010, 4'h0);

    // T5: zero length, stray engine pulse, error path, start ignored while busy
    set_cfg(3, 32'h5000, 32'h6000, 16'd0);
    start(4'b1000);
    chk("t5_zero_done", ch_done, 4'b1000);
    chk("t5_zero_busy", ch_busy, 4'h0);
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    chk("t5_zero_done_pulse", ch_done, 4'h0);
    chk("t5_stray_busy", ch_busy, 4'h0);
    tick();
    chk("t5_zero_no_cmd", cmd_valid, 1'b0);
    set_cfg(2, 32'h0100, 32'h0200, 16'd8);
    start(4'b0100);
    do_burst("t5_err", 2'd2, 32'h0100, 32'h0200, 5'd8, 1, 4'h0, 4'h0, 4'h0);
    chk("t5_err_set", ch_err, 4'b0100);
    tick();
    chk("t5_err_sticky", ch_err, 4'b0100);
    start(4'b0100);
    chk("t5_err_cleared", ch_err, 4'h0);
    set_cfg(2, 32'h0900, 32'h0900, 16'd4);
    start(4'b0100);
    do_burst("t5_reload", 2'd2, 32'h0100, 32'h0200, 5'd8, 0, 4'h0, 4'b0100, 4'h0);

    // T6: backpressure hold, then reset while waiting on the engine
    cmd_ready = 1'b0;
    set_cfg(0, 32'h1000, 32'h2000, 16'd16);
    start(4'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6_hold%0d_valid", k), cmd_valid, 1'b1);
      chk($sformatf("t6_hold%0d_fields", k), {cmd_chan, cmd_src, cmd_dst, cmd_beats},
          {2'd0, 32'h1000, 32'h2000, 5'd16});
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("t6_accepted", cmd_valid, 1'b0);
    chk("t6_wait_state", dbg_state, 2'd3);
    rst_n = 1'b0;
    tick();
    check_idle_outputs("t6_reset");
    rst_n = 1'b1;
    set_cfg(0, 32'h3000, 32'h5000, 16'd4);
    start(4'b0001);
    do_burst("t6_restart", 2'd0, 32'h3000, 32'h5000, 5'd4, 0, 4'h0, 4'b0001, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
